// File: rtl/write_arbiter.sv
`timescale 1ns/1ps
// write_arbiter
//   Packet-level arbiter between num_of_ports show-ahead input FIFOs and the
//   SRAM write path. In IDLE it grants one FIFO holding a complete packet,
//   then pops that packet word by word. Each word is forwarded on
//   selected_data_out together with the packet's destination port.
//   Arbitration is strict priority (sp0_wrr1=0) or weighted round robin
//   (sp0_wrr1=1). The mode is sampled only when a grant is made.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   sp0_wrr1             0 = strict priority, 1 = weighted round robin
//   ready/sop/eop/vld    per-FIFO status of the head word
//   data_in_p            packed head words, port i at [(i+1)*W-1 : i*W]
//   busy                 a packet is granted or in transfer
//   selected_data_out    registered forwarded word
//   arbiter_des_port_out destination port of the current packet
//   next_data            one-hot pop strobe to the granted FIFO
//   pre_selected         one-cycle pulse following the grant decision
//   transfering          selected_data_out holds a freshly popped word
module write_arbiter #(
    parameter int num_of_ports         = 16,
    parameter int arbiter_data_width   = 64,
    parameter int priority_width       = 3,
    parameter int fifo_data_width      = 64,
    parameter int fifo_num_of_priority = 8,
    parameter int fifo_length          = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sp0_wrr1,
    input  logic [num_of_ports-1:0]                 ready,
    input  logic [num_of_ports-1:0]                 sop,
    input  logic [num_of_ports-1:0]                 eop,
    input  logic [num_of_ports-1:0]                 vld,
    input  logic [num_of_ports*fifo_data_width-1:0] data_in_p,
    output logic                                    busy,
    output logic [arbiter_data_width-1:0]           selected_data_out,
    output logic [3:0]                              arbiter_des_port_out,
    output logic [num_of_ports-1:0]                 next_data,
    output logic                                    pre_selected,
    output logic                                    transfering
);

    localparam int PW  = $clog2(num_of_ports);
    localparam int CW  = $clog2(fifo_num_of_priority) + 1;
    localparam int WCW = $clog2(fifo_length) + 1;

    typedef enum logic [0:0] {IDLE, XFER} state_t;

    state_t                      state, state_next;
    logic [PW-1:0]               sel;
    logic [WCW-1:0]              cnt;
    logic [PW-1:0]               ptr;
    logic [CW-1:0]               credit     [num_of_ports];
    logic [CW-1:0]               eff_credit [num_of_ports];

    logic [fifo_data_width-1:0]  word [num_of_ports];
    logic [priority_width-1:0]   prio [num_of_ports];
    logic [num_of_ports-1:0]     eligible;

    logic                        sp_found, wrr_found, any_credit;
    logic [PW-1:0]               sp_port, wrr_port, grant_port;
    logic [priority_width-1:0]   sp_prio;
    logic                        grant_valid;
    logic                        pop;
    int unsigned                 idx;

    // Head word fields. A port only competes when its head is a valid header,
    // so a stale mid-packet head (e.g. after an aborted transfer) is ignored.
    always_comb begin
        for (int unsigned i = 0; i < num_of_ports; i++) begin
            word[i] = data_in_p[i*fifo_data_width +: fifo_data_width];
            prio[i] = word[i][4 +: priority_width];
        end
        eligible = ready & vld & sop;
    end

    // Strict priority: strict '>' keeps the lowest index on ties.
    always_comb begin
        sp_found = 1'b0;
        sp_port  = '0;
        sp_prio  = '0;
        for (int unsigned i = 0; i < num_of_ports; i++) begin
            if (eligible[i] && (!sp_found || prio[i] > sp_prio)) begin
                sp_found = 1'b1;
                sp_port  = PW'(i);
                sp_prio  = prio[i];
            end
        end
    end

    // Weighted round robin. When no eligible port has credit left, the
    // reloaded values are used directly so the reload and the grant happen
    // in the same decision cycle.
    always_comb begin
        any_credit = 1'b0;
        for (int unsigned i = 0; i < num_of_ports; i++) begin
            if (eligible[i] && credit[i] != '0) any_credit = 1'b1;
        end
        for (int unsigned i = 0; i < num_of_ports; i++) begin
            eff_credit[i] = any_credit ? credit[i] : CW'(prio[i]) + CW'(1);
        end
        wrr_found = 1'b0;
        wrr_port  = '0;
        idx       = 0;
        for (int unsigned k = 0; k < num_of_ports; k++) begin
            idx = (32'(ptr) + k) % num_of_ports;
            if (!wrr_found && eligible[idx] && eff_credit[idx] != '0) begin
                wrr_found = 1'b1;
                wrr_port  = PW'(idx);
            end
        end
    end

    assign grant_port  = sp0_wrr1 ? wrr_port  : sp_port;
    assign grant_valid = sp0_wrr1 ? wrr_found : sp_found;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state and pop strobe. The word counter forces the end of a
    // packet after fifo_length pops in case the eop flag never arrives.
    always_comb begin
        state_next = state;
        next_data  = '0;
        pop        = 1'b0;
        busy       = (state == XFER);
        case (state)
            IDLE: begin
                if (grant_valid) state_next = XFER;
            end
            XFER: begin
                if (vld[sel]) begin
                    pop            = 1'b1;
                    next_data[sel] = 1'b1;
                    if (eop[sel] || cnt == WCW'(fifo_length - 1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant bookkeeping and forwarding datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            sel                  <= '0;
            cnt                  <= '0;
            ptr                  <= '0;
            arbiter_des_port_out <= '0;
            pre_selected         <= 1'b0;
            selected_data_out    <= '0;
            transfering          <= 1'b0;
            for (int unsigned i = 0; i < num_of_ports; i++) credit[i] <= '0;
        end else begin
            pre_selected <= 1'b0;
            transfering  <= pop;
            if (state == IDLE && grant_valid) begin
                sel                  <= grant_port;
                arbiter_des_port_out <= word[grant_port][3:0];
                pre_selected         <= 1'b1;
                cnt                  <= '0;
                if (sp0_wrr1) begin
                    for (int unsigned i = 0; i < num_of_ports; i++) begin
                        if (PW'(i) == grant_port) credit[i] <= eff_credit[i] - CW'(1);
                        else                      credit[i] <= eff_credit[i];
                    end
                    if (eff_credit[grant_port] == CW'(1)) begin
                        ptr <= (grant_port == PW'(num_of_ports - 1)) ? '0 : grant_port + PW'(1);
                    end
                end
            end
            if (pop) begin
                selected_data_out <= arbiter_data_width'(word[sel]);
                cnt               <= cnt + WCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_write_arbiter.sv
`timescale 1ns/1ps
// Bench for write_arbiter: a show-ahead FIFO model per port feeds the DUT;
// a negedge monitor logs grants, destination ports, pops and forwarded words.
module tb_write_arbiter;

    localparam int P = 16;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           sp0_wrr1;
    logic [P-1:0]   ready, sop, eop, vld;
    logic [P*W-1:0] data_in_p;
    logic           busy;
    logic [W-1:0]   selected_data_out;
    logic [3:0]     arbiter_des_port_out;
    logic [P-1:0]   next_data;
    logic           pre_selected;
    logic           transfering;

    always #5 clk = ~clk;

    write_arbiter #(
        .num_of_ports(P), .arbiter_data_width(W), .priority_width(3),
        .fifo_data_width(W), .fifo_num_of_priority(8), .fifo_length(32)
    ) dut (
        .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1),
        .ready(ready), .sop(sop), .eop(eop), .vld(vld), .data_in_p(data_in_p),
        .busy(busy), .selected_data_out(selected_data_out),
        .arbiter_des_port_out(arbiter_des_port_out), .next_data(next_data),
        .pre_selected(pre_selected), .transfering(transfering)
    );

    logic [65:0] fq [P][$];      // {sop, eop, data}
    logic [P-1:0] stall;
    int passed = 0;
    int total  = 0;

    logic [63:0] words_log[$];
    logic [63:0] exp_words[$];
    int          grant_log[$];
    logic [3:0]  des_log[$];
    bit          tr_hist[$];
    int          pops;
    logic [P-1:0] nd_or;
    int          viol = 0;
    logic        prev_busy;
    int          mon_g;

    typedef struct {
        int   port;
        int   prio;
        int   dst;
        int   nbody;
        bit   with_eop;
        bit   mode;
        int   exp_pops;
    } vec_t;
    vec_t vecs[5];

    int sp_order  [16] = '{7, 15, 6, 14, 5, 13, 4, 12, 3, 11, 2, 10, 1, 9, 0, 8};
    int wrr_order [6]  = '{0, 0, 1, 0, 0, 1};
    int tog_order [3]  = '{1, 3, 6};
    int tog_dst   [3]  = '{4, 6, 7};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < P; i++) begin
            if (fq[i].size() > 0) begin
                ready[i] = 1'b1;
                vld[i]   = !stall[i];
                sop[i]   = fq[i][0][65];
                eop[i]   = fq[i][0][64];
                data_in_p[i*W +: W] = fq[i][0][63:0];
            end else begin
                ready[i] = 1'b0;
                vld[i]   = 1'b0;
                sop[i]   = 1'b0;
                eop[i]   = 1'b0;
                data_in_p[i*W +: W] = '0;
            end
        end
    endtask

    function automatic logic [63:0] mk_word(int port, int pkt, int idx, int prio, int dst);
        logic [63:0] w;
        w = {8'(port), 8'(pkt), 8'(idx), 40'h0};
        if (idx == 0) begin
            w[6:4] = 3'(prio);
            w[3:0] = 4'(dst);
        end else begin
            w[15:0] = 16'hB000 + 16'(idx);
        end
        return w;
    endfunction

    task automatic push_pkt(int port, int pkt, int prio, int dst, int nbody, bit with_eop);
        for (int k = 0; k <= nbody; k++) begin
            fq[port].push_back({(k == 0), (with_eop && k == nbody), mk_word(port, pkt, k, prio, dst)});
        end
        drive();
    endtask

    task automatic expect_pkt(int port, int pkt, int prio, int dst, int nbody);
        for (int k = 0; k <= nbody; k++) exp_words.push_back(mk_word(port, pkt, k, prio, dst));
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < P; i++) if (fq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_log();
        words_log.delete();
        exp_words.delete();
        grant_log.delete();
        des_log.delete();
        tr_hist.delete();
        pops  = 0;
        nd_or = '0;
    endtask

    task automatic wait_done(string name, int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (all_empty() && !busy && !transfering) ok = 1'b1;
        end
        chk({name, "_done"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_grant(string name, int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (pre_selected) ok = 1'b1;
        end
        chk({name, "_grant_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic chk_words(string name);
        int bad = 0;
        chk({name, "_word_count"}, 64'(words_log.size()), 64'(exp_words.size()));
        for (int k = 0; k < words_log.size() && k < exp_words.size(); k++) begin
            if (words_log[k] !== exp_words[k]) bad++;
        end
        chk({name, "_word_errors"}, 64'(bad), 64'd0);
    endtask

    // FIFO model: the pop request seen before the edge takes effect just after it.
    initial begin : fifo_model
        logic [P-1:0] pm;
        forever begin
            @(negedge clk);
            pm = next_data;
            @(posedge clk);
            #1;
            for (int i = 0; i < P; i++) begin
                if (pm[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            end
            drive();
        end
    end

    always @(negedge clk) begin
        if (pre_selected) begin
            mon_g = -1;
            for (int i = 0; i < P; i++) if (next_data[i]) mon_g = i;
            grant_log.push_back(mon_g);
            des_log.push_back(arbiter_des_port_out);
            if (prev_busy === 1'b1) viol++;
        end
        if (transfering) words_log.push_back(selected_data_out);
        if (next_data != '0) begin
            pops++;
            nd_or = nd_or | next_data;
        end
        if ($countones(next_data) > 1) viol++;
        if (next_data != '0 && !busy) viol++;
        tr_hist.push_back(transfering);
        prev_busy = busy;
    end

    initial begin : main
        int g, bad, first, last, gaps;
        rst      = 1'b1;
        sp0_wrr1 = 1'b0;
        stall    = '0;
        clear_log();
        drive();

        vecs[0] = '{port: 2,  prio: 2, dst: 5,  nbody: 4,  with_eop: 1, mode: 0, exp_pops: 5};
        vecs[1] = '{port: 0,  prio: 7, dst: 15, nbody: 0,  with_eop: 1, mode: 0, exp_pops: 1};
        vecs[2] = '{port: 15, prio: 0, dst: 0,  nbody: 2,  with_eop: 1, mode: 0, exp_pops: 3};
        vecs[3] = '{port: 7,  prio: 3, dst: 3,  nbody: 31, with_eop: 0, mode: 0, exp_pops: 32};
        vecs[4] = '{port: 9,  prio: 5, dst: 10, nbody: 1,  with_eop: 1, mode: 1, exp_pops: 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({busy, pre_selected, transfering, next_data, arbiter_des_port_out}), 64'd0);
        chk("reset_data", selected_data_out, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Single-packet vectors
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #2;
            clear_log();
            sp0_wrr1 = vecs[v].mode;
            push_pkt(vecs[v].port, v, vecs[v].prio, vecs[v].dst, vecs[v].nbody, vecs[v].with_eop);
            expect_pkt(vecs[v].port, v, vecs[v].prio, vecs[v].dst, vecs[v].nbody);
            wait_done($sformatf("vec%0d", v), 120);
            @(negedge clk);
            g = (grant_log.size() > 0) ? grant_log[0] : -1;
            chk($sformatf("vec%0d_grants", v), 64'(grant_log.size()), 64'd1);
            chk($sformatf("vec%0d_port", v), 64'(g), 64'(vecs[v].port));
            chk($sformatf("vec%0d_des", v), 64'((des_log.size() > 0) ? des_log[0] : 4'hx), 64'(vecs[v].dst));
            chk($sformatf("vec%0d_pops", v), 64'(pops), 64'(vecs[v].exp_pops));
            chk($sformatf("vec%0d_mask", v), 64'(nd_or), 64'(16'd1 << vecs[v].port));
            chk_words($sformatf("vec%0d", v));
        end

        // Strict priority with all 16 ports ready
        @(posedge clk); #2;
        clear_log();
        sp0_wrr1 = 1'b0;
        for (int i = 0; i < P; i++) push_pkt(i, 20 + i, i % 8, i, 1, 1'b1);
        for (int k = 0; k < 16; k++) expect_pkt(sp_order[k], 20 + sp_order[k], sp_order[k] % 8, sp_order[k], 1);
        wait_done("sp16", 600);
        chk("sp16_grants", 64'(grant_log.size()), 64'd16);
        bad = 0;
        for (int k = 0; k < grant_log.size() && k < 16; k++) begin
            if (grant_log[k] != sp_order[k] || des_log[k] != 4'(sp_order[k])) bad++;
        end
        chk("sp16_order_errors", 64'(bad), 64'd0);
        chk_words("sp16");

        // Stall: vld dropped for 3 cycles mid-packet
        @(posedge clk); #2;
        clear_log();
        push_pkt(3, 30, 4, 12, 6, 1'b1);
        expect_pkt(3, 30, 4, 12, 6);
        wait_grant("stall", 20);
        @(posedge clk); #2;
        @(posedge clk); #2;
        stall[3] = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #2;
        stall[3] = 1'b0;
        drive();
        wait_done("stall", 60);
        first = -1; last = -1; gaps = 0;
        for (int k = 0; k < tr_hist.size(); k++) if (tr_hist[k]) begin
            if (first < 0) first = k;
            last = k;
        end
        for (int k = first; k >= 0 && k <= last; k++) if (!tr_hist[k]) gaps++;
        chk("stall_gap", 64'(gaps), 64'd3);
        chk("stall_pops", 64'(pops), 64'd7);
        chk_words("stall");

        // WRR from a fresh reset: ports 0 (prio 1) and 1 (prio 0)
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        clear_log();
        sp0_wrr1 = 1'b1;
        for (int k = 0; k < 4; k++) push_pkt(0, 40 + k, 1, 1, 1, 1'b1);
        for (int k = 0; k < 2; k++) push_pkt(1, 50 + k, 0, 2, 2, 1'b1);
        expect_pkt(0, 40, 1, 1, 1);
        expect_pkt(0, 41, 1, 1, 1);
        expect_pkt(1, 50, 0, 2, 2);
        expect_pkt(0, 42, 1, 1, 1);
        expect_pkt(0, 43, 1, 1, 1);
        expect_pkt(1, 51, 0, 2, 2);
        wait_done("wrr", 300);
        chk("wrr_grants", 64'(grant_log.size()), 64'd6);
        bad = 0;
        for (int k = 0; k < grant_log.size() && k < 6; k++) if (grant_log[k] != wrr_order[k]) bad++;
        chk("wrr_order_errors", 64'(bad), 64'd0);
        chk_words("wrr");

        // Reset in the middle of a transfer
        @(posedge clk); #2;
        clear_log();
        sp0_wrr1 = 1'b0;
        push_pkt(4, 60, 3, 9, 6, 1'b1);
        wait_grant("rstmid", 20);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_ctrl", 64'({busy, pre_selected, transfering, next_data, arbiter_des_port_out}), 64'd0);
        chk("rstmid_data", selected_data_out, 64'd0);
        fq[4].delete();
        push_pkt(4, 61, 3, 11, 2, 1'b1);
        @(posedge clk); #2;
        clear_log();
        expect_pkt(4, 61, 3, 11, 2);
        @(negedge clk);
        chk("rstmid_hold", 64'({busy, pre_selected, next_data}), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        wait_done("rstmid", 60);
        chk("rstmid_grants", 64'(grant_log.size()), 64'd1);
        chk("rstmid_des", 64'((des_log.size() > 0) ? des_log[0] : 4'hx), 64'd11);
        chk_words("rstmid");

        // Mode switched to WRR while a strict-priority packet is in flight
        @(posedge clk); #2;
        clear_log();
        sp0_wrr1 = 1'b0;
        push_pkt(1, 70, 0, 4, 5, 1'b1);
        expect_pkt(1, 70, 0, 4, 5);
        expect_pkt(3, 71, 2, 6, 1);
        expect_pkt(6, 72, 5, 7, 1);
        wait_grant("toggle", 20);
        @(posedge clk); #2;
        sp0_wrr1 = 1'b1;
        push_pkt(3, 71, 2, 6, 1, 1'b1);
        push_pkt(6, 72, 5, 7, 1, 1'b1);
        wait_done("toggle", 100);
        chk("toggle_grants", 64'(grant_log.size()), 64'd3);
        bad = 0;
        for (int k = 0; k < grant_log.size() && k < 3; k++) begin
            if (grant_log[k] != tog_order[k] || des_log[k] != 4'(tog_dst[k])) bad++;
        end
        chk("toggle_order_errors", 64'(bad), 64'd0);
        chk_words("toggle");

        chk("invariant_violations", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
